// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: a single-outstanding AXI4-lite read master feeding an
// in-order instruction buffer of {inst, pc, err} entries, with redirect/flush support.
module ifu_prefetch #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               ifu_valid,
  output logic [2*WIDTH-1:0] ifu_data,
  output logic               ifu_err,
  input  logic               idu_ready,
  output logic [WIDTH-1:0]   ARADDR,
  output logic               ARVALID,
  input  logic               ARREADY,
  input  logic [WIDTH-1:0]   RDATA,
  input  logic [1:0]         RRESP,
  input  logic               RVALID,
  output logic               RREADY
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_DRAIN, S_HALT} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] fpc;
  logic [WIDTH-1:0] araddr_q;
  logic             arvalid_q;
  logic             rready_q;
  logic             kill_q;

  logic [WIDTH-1:0] buf_inst [DEPTH];
  logic [WIDTH-1:0] buf_pc   [DEPTH];
  logic             buf_err  [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic has_room;
  logic push;
  logic pop;

  // Only one read is ever in flight and AR is only issued from S_IDLE, so
  // occupancy alone decides whether another fetch can fit.
  assign has_room = count < CNT_W'(DEPTH);
  assign push     = (state == S_R) && RVALID && !redirect_valid;
  assign pop      = ifu_valid && idu_ready && !redirect_valid;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (!redirect_valid && has_room) next_state = S_AR;
      S_AR:    if (ARREADY) next_state = (kill_q || redirect_valid) ? S_DRAIN : S_R;
      S_R: begin
        if (redirect_valid)  next_state = RVALID ? S_IDLE : S_DRAIN;
        else if (RVALID)     next_state = (RRESP != 2'b00) ? S_HALT : S_IDLE;
      end
      // A beat returning in the same cycle as a redirect still completes the drain;
      // waiting for another beat here would never finish.
      S_DRAIN: if (RVALID) next_state = S_IDLE;
      S_HALT:  if (redirect_valid) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      fpc       <= RESET_PC;
      araddr_q  <= RESET_PC;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      state     <= next_state;
      arvalid_q <= (next_state == S_AR);
      rready_q  <= (next_state == S_R) || (next_state == S_DRAIN);
      if (state == S_IDLE && next_state == S_AR) araddr_q <= fpc;
      if (redirect_valid)  fpc <= redirect_pc;
      else if (push)       fpc <= araddr_q + WIDTH'(4);
      // Remembers a redirect seen while the address is still waiting for ARREADY.
      if (state == S_AR) kill_q <= !ARREADY && (kill_q || redirect_valid);
      else               kill_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= RDATA;
      buf_pc[wr_ptr]   <= araddr_q;
      buf_err[wr_ptr]  <= (RRESP != 2'b00);
    end
  end

  assign ifu_valid = (count != '0);
  assign ifu_data  = ifu_valid ? {buf_inst[rd_ptr], buf_pc[rd_ptr]} : '0;
  assign ifu_err   = ifu_valid & buf_err[rd_ptr];
  assign ARADDR    = araddr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule
